byte_loaded_instruction_memory: RTL

- Parametrised successor to the word-write instruction memory in the IF stage.
- Program load is byte-serial (byte-stream link from the debug unit) with a valid/ready handshake; bytes are packed big-endian into words and appended at an auto-incrementing write pointer.
- Memory zeroes itself with a sweep after reset or clear; reports fill level, full state and load completion.
- The fetch stage reads words combinationally by byte-addressed PC.

---
 rtl/byte_loaded_instruction_memory_pkg.sv | 13 +
 rtl/byte_loaded_instruction_memory_packer.sv | 52 +++++
 rtl/byte_loaded_instruction_memory.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/byte_loaded_instruction_memory_pkg.sv
// Shared types and constants for the byte-loaded instruction memory.
// Holds the controller state encoding and the byte width used by the load path.
package instruction_memory_pkg;

  localparam int BYTE_SIZE = 8;

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_loaded_instruction_memory_packer.sv
// byte_word_packer: assembles a big-endian word from a byte stream and pulses
// word_valid combinationally on the edge that accepts the final byte.
module byte_word_packer
  import instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    flush,
  input  logic [BYTE_SIZE-1:0]                    data_byte,
  input  logic                                    accept,
  output logic                                    word_valid,
  output logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] word
);

  localparam int W     = BYTE_SIZE * WORD_SIZE_IN_BYTES;
  localparam int IDX_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE_IN_BYTES - 1);

  logic [IDX_W-1:0] byte_idx_reg;

  assign word_valid = accept && (byte_idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      byte_idx_reg <= '0;
    end else if (accept) begin
      byte_idx_reg <= (byte_idx_reg == LAST_IDX) ? '0 : byte_idx_reg + 1'b1;
    end
  end

  // Only the W-8 bits of earlier bytes are stored; the incoming byte completes the word.
  generate
    if (WORD_SIZE_IN_BYTES > 1) begin : g_shift
      logic [W-BYTE_SIZE-1:0] shift_reg;

      assign word = {shift_reg, data_byte};

      always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
          shift_reg <= '0;
        end else if (accept) begin
          shift_reg <= word[W-BYTE_SIZE-1:0];
        end
      end
    end else begin : g_single
      assign word = data_byte;
    end
  endgenerate

endmodule

// File: rtl/byte_loaded_instruction_memory.sv
// Instruction memory loaded through a byte-serial valid/ready stream, self-zeroing
// after reset/clear, with a combinational PC-indexed fetch port.
// Optional halt detection (all-zero word ends the load) under INSTRUCTION_MEMORY_HALT_DETECT_EN.
module byte_loaded_instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  parameter int PC_SIZE            = $clog2(MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES),
  parameter int COUNT_SIZE         = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_clear,
  input  logic                                    i_byte_valid,
  input  logic [BYTE_SIZE-1:0]                    i_byte,
  output logic                                    o_byte_ready,
  input  logic [PC_SIZE-1:0]                      i_pc,
  output logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] o_instruction,
  output logic                                    o_pc_out_of_range,
  output logic [COUNT_SIZE-1:0]                   o_word_count,
  output logic                                    o_full,
  output logic                                    o_busy,
  output logic                                    o_load_done
);

  localparam int W          = BYTE_SIZE * WORD_SIZE_IN_BYTES;
  localparam int ADDR_W     = (MEM_SIZE_IN_WORDS > 1) ? $clog2(MEM_SIZE_IN_WORDS) : 1;
  localparam int WORD_SHIFT = $clog2(WORD_SIZE_IN_BYTES);
  localparam logic [ADDR_W-1:0]     LAST_ADDR  = ADDR_W'(MEM_SIZE_IN_WORDS - 1);
  localparam logic [COUNT_SIZE-1:0] FULL_COUNT = COUNT_SIZE'(MEM_SIZE_IN_WORDS);
  localparam logic [PC_SIZE:0]      DEPTH_PC   = (PC_SIZE + 1)'(MEM_SIZE_IN_WORDS);

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_W-1:0]       sweep_ptr_reg;
  logic [COUNT_SIZE-1:0]   count_reg;
  logic [W-1:0]            mem [MEM_SIZE_IN_WORDS];

  logic                    accept;
  logic                    word_valid;
  logic                    commit;
  logic                    halt;
  logic                    busy;
  logic                    byte_ready;
  logic                    full;
  logic [W-1:0]            packed_word;
  logic [PC_SIZE-1:0]      pc_index;
  logic                    in_range;

  assign full   = (count_reg == FULL_COUNT);
  assign accept = i_byte_valid && byte_ready;
  // A clear on the commit edge discards the word, so it never reaches the array.
  assign commit = word_valid && !i_clear;

`ifdef INSTRUCTION_MEMORY_HALT_DETECT_EN
  logic load_done_reg;

  assign halt = commit && (packed_word == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      load_done_reg <= 1'b0;
    end else if (halt) begin
      load_done_reg <= 1'b1;
    end
  end

  assign o_load_done = load_done_reg;
`else
  assign halt        = 1'b0;
  assign o_load_done = 1'b0;
`endif

  byte_word_packer #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_packer (
    .clk       (i_clk),
    .reset_n   (i_reset),
    .flush     (i_clear),
    .data_byte (i_byte),
    .accept    (accept),
    .word_valid(word_valid),
    .word      (packed_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_reg <= SWEEP;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_clear) begin
      state_next = SWEEP;
    end else begin
      case (state_reg)
        SWEEP:   if (sweep_ptr_reg == LAST_ADDR) state_next = LOAD;
        LOAD:    if (halt) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = SWEEP;
      endcase
    end
  end

  always_comb begin
    busy       = (state_reg == SWEEP);
    byte_ready = (state_reg == LOAD) && !full;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      sweep_ptr_reg <= '0;
    end else if (state_reg == SWEEP) begin
      sweep_ptr_reg <= (sweep_ptr_reg == LAST_ADDR) ? '0 : sweep_ptr_reg + 1'b1;
    end
  end

  // The fill count doubles as the write pointer.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      count_reg <= '0;
    end else if (commit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if (state_reg == SWEEP) begin
        mem[sweep_ptr_reg] <= '0;
      end else if (commit) begin
        mem[count_reg[ADDR_W-1:0]] <= packed_word;
      end
    end
  end

  assign pc_index          = i_pc >> WORD_SHIFT;
  assign in_range          = ({1'b0, pc_index} < DEPTH_PC);
  assign o_instruction     = in_range ? mem[pc_index[ADDR_W-1:0]] : '0;
  assign o_pc_out_of_range = !in_range;

  assign o_byte_ready = byte_ready;
  assign o_word_count = count_reg;
  assign o_full       = full;
  assign o_busy       = busy;

endmodule
